// File: rtl/mmcm_lock_seq.sv
//-----------------------------------------------------------------------------
// mmcm_lock_seq
//
// Reset/lock sequencer for NCH clocking primitives (MMCM/PLL) that share one
// free-running reference clock. Each attempt holds the primitives in reset,
// waits for all enabled LOCKED inputs (with timeout and retry), requires a
// stability window of continuous lock, and then raises `ready`. Lock loss
// while ready is counted (saturating at 255).
//
// Build option:
//   MMCM_LOCK_SEQ_AUTORECOVER_EN
//     defined   : lock loss in READY starts a fresh attempt (HOLD) with the
//                 retry count cleared; the block re-locks on its own.
//     undefined : lock loss in READY parks the block in LOST until restart
//                 or aresetn, leaving downstream logic quiesced.
//
// Ports:
//   clk        in   reference clock; everything is synchronous to it
//   aresetn    in   asynchronous active-low reset
//   locked     in   [NCH]  raw LOCKED outputs (asynchronous to clk)
//   chan_en    in   [NCH]  channel enable mask (change only with restart)
//   restart    in   single-cycle pulse, restarts the whole sequence
//   mmcm_rst   out  [NCH]  per-primitive reset, active high
//   ready      out  all enabled channels locked and stable
//   fail       out  retries exhausted (sticky until restart/aresetn)
//   state      out  [3]    FSM state: 0 HOLD, 1 WAIT_LOCK, 2 STABLE,
//                          3 READY, 4 FAIL, 5 LOST
//   retry_cnt  out  failed lock attempts in the current sequence
//   loss_cnt   out  [8]    lock-loss events seen in READY, saturating
//-----------------------------------------------------------------------------
module mmcm_lock_seq #(
  parameter int NCH           = 2,
  parameter int HOLD_CYCLES   = 100,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 64,
  parameter int MAX_RETRY     = 3
) (
  input  logic                           clk,
  input  logic                           aresetn,
  input  logic [NCH-1:0]                 locked,
  input  logic [NCH-1:0]                 chan_en,
  input  logic                           restart,
  output logic [NCH-1:0]                 mmcm_rst,
  output logic                           ready,
  output logic                           fail,
  output logic [2:0]                     state,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
  output logic [7:0]                     loss_cnt
);

  localparam int RW         = $clog2(MAX_RETRY + 1);
  localparam int CNT_MAX_HL = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX    = (CNT_MAX_HL > STABLE_CYCLES) ? CNT_MAX_HL : STABLE_CYCLES;
  // The counter only ever holds 0..CNT_MAX-1.
  localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0]    RETRY_LIMIT  = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_READY     = 3'd3,
    S_FAIL      = 3'd4,
    S_LOST      = 3'd5
  } state_e;

  logic [NCH-1:0]   lk_meta_q;
  logic [NCH-1:0]   lk_sync_q;
  logic             all_lk;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             rst_int_d;

  logic [NCH-1:0]   mmcm_rst_q;
  logic             ready_q;
  logic             fail_q;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // LOCKED is asynchronous to clk: two-flop synchroniser per channel.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      lk_meta_q <= '0;
      lk_sync_q <= '0;
    end else begin
      lk_meta_q <= locked;
      lk_sync_q <= lk_meta_q;
    end
  end

  // Disabled channels count as locked, so an empty mask passes straight
  // through the lock and stability checks.
  assign all_lk = &(lk_sync_q | ~chan_en);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    if (restart) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      retry_d = '0;
      loss_d  = '0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_WAIT_LOCK: begin
          // Lock is tested before the timeout so lock on the last cycle wins.
          if (all_lk) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = retry_q + RW'(1);
            cnt_d   = '0;
            state_d = (retry_d == RETRY_LIMIT) ? S_FAIL : S_HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_STABLE: begin
          // A dropout here is not a failed attempt: retry_cnt is untouched.
          if (!all_lk) begin
            state_d = S_HOLD;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_READY: begin
          if (!all_lk) begin
            loss_d = sat_inc8(loss_q);
            cnt_d  = '0;
`ifdef MMCM_LOCK_SEQ_AUTORECOVER_EN
            state_d = S_HOLD;
            retry_d = '0;
`else
            state_d = S_LOST;
`endif
          end
        end

        S_FAIL, S_LOST: begin
          // Parked until restart or aresetn.
        end

        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Primitive reset is asserted while holding and after giving up.
  assign rst_int_d = (state_d == S_HOLD) || (state_d == S_FAIL);

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_HOLD;
      cnt_q      <= '0;
      retry_q    <= '0;
      loss_q     <= '0;
      mmcm_rst_q <= '1;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      loss_q     <= loss_d;
      mmcm_rst_q <= chan_en & {NCH{rst_int_d}};
      ready_q    <= (state_d == S_READY);
      fail_q     <= (state_d == S_FAIL);
    end
  end

  assign mmcm_rst  = mmcm_rst_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_mmcm_lock_seq.sv
//-----------------------------------------------------------------------------
// tb_mmcm_lock_seq
//
// Self-checking bench for mmcm_lock_seq with default parameters. A reference
// model tracks the phase of the sequence and how long it has been in that
// phase; a compare process checks every DUT output against it on every
// falling edge. Directed scenarios pin the model with literal cycle counts,
// then a randomised run exercises lock glitches, restarts and masks.
//-----------------------------------------------------------------------------
module tb_mmcm_lock_seq;

  localparam int NCH  = 2;
  localparam int HOLD = 100;
  localparam int TO   = 4096;
  localparam int STB  = 64;
  localparam int MR   = 3;

  logic           clk     = 1'b0;
  logic           aresetn = 1'b0;
  logic [NCH-1:0] locked  = '0;
  logic [NCH-1:0] chan_en = '1;
  logic           restart = 1'b0;
  logic [NCH-1:0] mmcm_rst;
  logic           ready;
  logic           fail;
  logic [2:0]     state;
  logic [1:0]     retry_cnt;
  logic [7:0]     loss_cnt;

  mmcm_lock_seq #(
    .NCH(NCH), .HOLD_CYCLES(HOLD), .LOCK_TIMEOUT(TO),
    .STABLE_CYCLES(STB), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .aresetn(aresetn), .locked(locked), .chan_en(chan_en),
    .restart(restart), .mmcm_rst(mmcm_rst), .ready(ready), .fail(fail),
    .state(state), .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int prints      = 0;

  function automatic void chk(string nm, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      if (prints < 60) begin
        prints++;
        $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
      end
    end
  endfunction

  // Reference model: phase numbers follow the documented state encoding;
  // m_age counts clock edges spent in the current phase.
  int             m_ph, m_age, m_retry, m_loss, m_nxt;
  logic [NCH-1:0] m_s1, m_s2, m_rst;
  bit             m_lk, m_live;

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_ph = 0; m_age = 0; m_retry = 0; m_loss = 0;
      m_s1 = '0; m_s2 = '0; m_rst = '1; m_live = 0;
    end else begin
      m_lk  = &(m_s2 | ~chan_en);
      m_s2  = m_s1;
      m_s1  = locked;
      m_nxt = m_ph;
      m_age++;
      if (restart) begin
        m_nxt = 0; m_retry = 0; m_loss = 0;
      end else begin
        case (m_ph)
          0: if (m_age == HOLD) m_nxt = 1;
          1: if (m_lk) m_nxt = 2;
             else if (m_age == TO) begin
               m_retry++;
               m_nxt = (m_retry == MR) ? 4 : 0;
             end
          2: if (!m_lk) m_nxt = 0;
             else if (m_age == STB) m_nxt = 3;
          3: if (!m_lk) begin
               if (m_loss < 255) m_loss++;
`ifdef MMCM_LOCK_SEQ_AUTORECOVER_EN
               m_nxt = 0; m_retry = 0;
`else
               m_nxt = 5;
`endif
             end
          default: ;
        endcase
      end
      if (restart || m_nxt != m_ph) m_age = 0;
      m_ph   = m_nxt;
      m_rst  = (m_ph == 0 || m_ph == 4) ? chan_en : '0;
      m_live = 1;
    end
  end

  always @(negedge clk) begin
    if (aresetn && m_live) begin
      chk("cyc_mmcm_rst", mmcm_rst, m_rst);
      chk("cyc_ready", ready, m_ph == 3);
      chk("cyc_fail", fail, m_ph == 4);
      chk("cyc_state", state, m_ph);
      chk("cyc_retry", retry_cnt, m_retry);
      chk("cyc_loss", loss_cnt, m_loss);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_restart(input logic [NCH-1:0] en);
    chan_en = en;
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic wait_state(input string nm, input logic [2:0] s, input int lim);
    int n = 0;
    while (state != s && n < lim) begin tick(); n++; end
    chk(nm, state, s);
  endtask

  task automatic wait_ready(input string nm, input int lim);
    int n = 0;
    while (!ready && n < lim) begin tick(); n++; end
    chk(nm, ready, 1);
  endtask

  int  n, rst_hi, first_rdy, entries;
  bit  seen0, seen1;
  logic [2:0] prev;

  initial begin
    // Power-up with both channels enabled
    repeat (3) @(posedge clk);
    #2;
    chk("rst_mmcm_rst", mmcm_rst, 2'b11);
    chk("rst_ready", ready, 0);
    chk("rst_fail", fail, 0);
    chk("rst_state", state, 0);
    chk("rst_retry", retry_cnt, 0);
    chk("rst_loss", loss_cnt, 0);
    aresetn   = 1'b1;
    rst_hi    = (mmcm_rst == 2'b11) ? 1 : 0;
    first_rdy = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (mmcm_rst == 2'b11) rst_hi++;
      if (ready && first_rdy == 0) first_rdy = i;
      if (i == 120) locked = 2'b11;
    end
    chk("pwr_rst_cycles", rst_hi, 100);
    chk("pwr_ready_cycle", first_rdy, 187);
    chk("pwr_retry", retry_cnt, 0);

    // Lock loss while READY
    locked = 2'b10;
    n = 0;
    while (ready && n < 10) begin tick(); n++; end
    chk("loss_ready_fall", n, 3);
    chk("loss_cnt_one", loss_cnt, 1);
`ifdef MMCM_LOCK_SEQ_AUTORECOVER_EN
    chk("loss_state_hold", state, 0);
    locked = 2'b11;
    wait_ready("loss_recover_ready", 400);
    chk("loss_recover_cnt", loss_cnt, 1);
    chk("loss_recover_retry", retry_cnt, 0);
`else
    chk("loss_state_lost", state, 5);
    repeat (50) tick();
    chk("lost_stays", state, 5);
    chk("lost_mmcm_rst", mmcm_rst, 2'b00);
    locked = 2'b11;
    repeat (20) tick();
    chk("lost_no_relock", state, 5);
    chk("lost_ready_low", ready, 0);
`endif

    // Stability dropout on channel 1, thirty cycles into STABLE
    locked = 2'b00;
    pulse_restart(2'b11);
    chk("rstrt_loss_clr", loss_cnt, 0);
    wait_state("drop_wait_lock", 3'd1, 200);
    locked = 2'b11;
    wait_state("drop_stable", 3'd2, 20);
    repeat (30) tick();
    locked = 2'b01;
    n = 0;
    while (state != 3'd0 && n < 10) begin tick(); n++; end
    chk("drop_to_hold", n, 3);
    chk("drop_retry", retry_cnt, 0);
    repeat (2) tick();
    locked = 2'b11;
    n = 2;
    while (!ready && n < 400) begin tick(); n++; end
    chk("drop_ready_cycles", n, HOLD + 1 + STB);
    chk("drop_retry_after", retry_cnt, 0);

    // Mask: only channel 0 enabled, channel 1 never locks
    locked = 2'b00;
    pulse_restart(2'b01);
    seen0 = mmcm_rst[0];
    seen1 = mmcm_rst[1];
    n = 0;
    while (!ready && n < 400) begin
      tick(); n++;
      seen0 |= mmcm_rst[0];
      seen1 |= mmcm_rst[1];
      if (state == 3'd1) locked = 2'b01;
    end
    chk("mask_ready", ready, 1);
    chk("mask_rst0_seen", seen0, 1);
    chk("mask_rst1_never", seen1, 0);

    // Empty mask: locked is ignored entirely
    locked = 2'b00;
    pulse_restart(2'b00);
    seen0 = 0;
    n = 0;
    while (!ready && n < 400) begin tick(); n++; seen0 |= |mmcm_rst; end
    chk("empty_ready_cycles", n, HOLD + 1 + STB);
    chk("empty_mmcm_rst", seen0, 0);

    // Never lock: three attempts, then FAIL
    locked = 2'b00;
    pulse_restart(2'b11);
    prev = state;
    entries = 0;
    n = 0;
    while (!fail && n < 15000) begin
      tick(); n++;
      if (state == 3'd1 && prev == 3'd0) entries++;
      prev = state;
    end
    chk("nl_fail_cycles", n, 3 * (HOLD + TO));
    chk("nl_attempts", entries, 3);
    chk("nl_retry", retry_cnt, 3);
    chk("nl_mmcm_rst", mmcm_rst, 2'b11);
    chk("nl_state", state, 4);
    repeat (20) tick();
    chk("nl_sticky", fail, 1);
    pulse_restart(2'b11);
    chk("nl_rstrt_fail", fail, 0);
    chk("nl_rstrt_retry", retry_cnt, 0);
    chk("nl_rstrt_state", state, 0);

    // Async reset in STABLE after one failed attempt
    n = 0;
    while (retry_cnt != 2'd1 && n < 5000) begin tick(); n++; end
    chk("ar_one_retry", retry_cnt, 1);
    locked = 2'b11;
    wait_state("ar_stable", 3'd2, 300);
    repeat (10) tick();
    #1 aresetn = 1'b0;
    #1;
    chk("ar_mmcm_rst", mmcm_rst, 2'b11);
    chk("ar_ready", ready, 0);
    chk("ar_fail", fail, 0);
    chk("ar_state", state, 0);
    chk("ar_retry", retry_cnt, 0);
    chk("ar_loss", loss_cnt, 0);
    tick();
    aresetn = 1'b1;

`ifdef MMCM_LOCK_SEQ_AUTORECOVER_EN
    // Repeated loss/recover: loss_cnt saturates at 255
    for (int i = 0; i < 260; i++) begin
      wait_ready("sat_ready", 400);
      locked = 2'b10;
      repeat (4) tick();
      locked = 2'b11;
    end
    repeat (5) tick();
    chk("sat_loss", loss_cnt, 255);
`endif

    // Randomised lock glitches, restarts and masks
    for (int i = 0; i < 15000; i++) begin
      restart = 1'b0;
      if ($urandom_range(0, 2499) == 0) begin
        chan_en = 2'($urandom);
        restart = 1'b1;
      end
      if ($urandom_range(0, 149) == 0) locked[$urandom_range(0, 1)] ^= 1'b1;
      tick();
    end
    restart = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
